// File: rtl/rv_hazard_scoreboard.sv
// rv_hazard_scoreboard
//   Hazard and forwarding controller for the 5-stage RV32 pipeline.
//   A DEPTH-slot shift scoreboard tracks in-flight destinations
//   (slot 1 = EX, slot 2 = MEM, ..., slot DEPTH = WB). From that state the
//   block produces:
//     - load-use and ID-branch stalls (combinational)
//     - EX operand forward selects (combinational)
//   Optional feature macro: HAZ_PERF_CNT_EN adds a saturating stall-cycle
//   counter on port stall_cnt. When the macro is undefined, the port and the
//   counter logic are absent.

module rv_hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    localparam int FW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              id_is_branch,
    input  logic              flush,
    output logic              stall,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic              ex_valid
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    // Scoreboard state. Index 1 is the EX stage, index DEPTH is WB.
    logic [DEPTH:1]    slot_valid_r;
    logic [DEPTH:1]    slot_regwrite_r;
    logic [DEPTH:1]    slot_is_load_r;
    logic [REG_AW-1:0] slot_rd_r [1:DEPTH];
    logic [REG_AW-1:0] ex_rs1_r;
    logic [REG_AW-1:0] ex_rs2_r;

    // Combinational hazard / forward results.
    logic              m1_rs1_s;
    logic              m1_rs2_s;
    logic              m2_rs1_s;
    logic              m2_rs2_s;
    logic              load_use_s;
    logic              branch_haz_s;
    logic              stall_s;
    logic              capture_s;
    logic [FW-1:0]     fwd_a_s;
    logic [FW-1:0]     fwd_b_s;

    // A producer slot matches a consumer source. Register 0 never matches,
    // and a source that the consumer does not read never matches.
    function automatic logic slot_match(
        input logic              valid,
        input logic              regwrite,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs,
        input logic              use_rs
    );
        return valid & regwrite & use_rs &
               (rs != {REG_AW{1'b0}}) & (rd == rs);
    endfunction

    // Stall generation: a load-use in EX, or a branch in ID that needs a
    // value that is not yet obtainable. Flush overrides every hazard.
    always_comb begin
        m1_rs1_s = slot_match(slot_valid_r[1], slot_regwrite_r[1], slot_rd_r[1],
                              id_rs1, id_use_rs1);
        m1_rs2_s = slot_match(slot_valid_r[1], slot_regwrite_r[1], slot_rd_r[1],
                              id_rs2, id_use_rs2);
        m2_rs1_s = slot_match(slot_valid_r[2], slot_regwrite_r[2], slot_rd_r[2],
                              id_rs1, id_use_rs1);
        m2_rs2_s = slot_match(slot_valid_r[2], slot_regwrite_r[2], slot_rd_r[2],
                              id_rs2, id_use_rs2);

        load_use_s   = (m1_rs1_s | m1_rs2_s) & slot_is_load_r[1];
        branch_haz_s = id_is_branch &
                       ((m1_rs1_s | m1_rs2_s) |
                        ((m2_rs1_s | m2_rs2_s) & slot_is_load_r[2]));

        if (id_valid && !flush) begin
            stall_s = load_use_s | branch_haz_s;
        end else begin
            stall_s = 1'b0;
        end

        capture_s = id_valid & ~flush & ~stall_s;
    end

    // Forward selects for the EX instruction. The loop walks from the oldest
    // slot to the youngest, so the youngest match overwrites older ones.
    // A load sitting in MEM (slot 2) has no data yet and is never a source.
    always_comb begin
        fwd_a_s = {FW{1'b0}};
        fwd_b_s = {FW{1'b0}};
        for (int j = DEPTH; j >= 2; j--) begin
            if (slot_match(slot_valid_r[j], slot_regwrite_r[j], slot_rd_r[j],
                           ex_rs1_r, slot_valid_r[1]) &&
                !((j == 2) && slot_is_load_r[j])) begin
                fwd_a_s = FW'(j - 1);
            end else begin
                fwd_a_s = fwd_a_s;
            end
            if (slot_match(slot_valid_r[j], slot_regwrite_r[j], slot_rd_r[j],
                           ex_rs2_r, slot_valid_r[1]) &&
                !((j == 2) && slot_is_load_r[j])) begin
                fwd_b_s = FW'(j - 1);
            end else begin
                fwd_b_s = fwd_b_s;
            end
        end
    end

    // Scoreboard shift: older slots always advance; slot 1 takes the ID
    // instruction or a bubble when ID is invalid, flushed or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j <= DEPTH; j++) begin
                slot_valid_r[j]    <= 1'b0;
                slot_regwrite_r[j] <= 1'b0;
                slot_is_load_r[j]  <= 1'b0;
                slot_rd_r[j]       <= {REG_AW{1'b0}};
            end
            ex_rs1_r <= {REG_AW{1'b0}};
            ex_rs2_r <= {REG_AW{1'b0}};
        end else begin
            for (int j = 2; j <= DEPTH; j++) begin
                slot_valid_r[j]    <= slot_valid_r[j-1];
                slot_regwrite_r[j] <= slot_regwrite_r[j-1];
                slot_is_load_r[j]  <= slot_is_load_r[j-1];
                slot_rd_r[j]       <= slot_rd_r[j-1];
            end
            if (capture_s) begin
                slot_valid_r[1]    <= 1'b1;
                slot_regwrite_r[1] <= id_regwrite;
                slot_is_load_r[1]  <= id_is_load;
                slot_rd_r[1]       <= id_rd;
                ex_rs1_r           <= id_use_rs1 ? id_rs1 : {REG_AW{1'b0}};
                ex_rs2_r           <= id_use_rs2 ? id_rs2 : {REG_AW{1'b0}};
            end else begin
                slot_valid_r[1]    <= 1'b0;
                slot_regwrite_r[1] <= 1'b0;
                slot_is_load_r[1]  <= 1'b0;
                slot_rd_r[1]       <= {REG_AW{1'b0}};
                ex_rs1_r           <= {REG_AW{1'b0}};
                ex_rs2_r           <= {REG_AW{1'b0}};
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign stall    = stall_s;
    assign fwd_a    = fwd_a_s;
    assign fwd_b    = fwd_b_s;
    assign ex_valid = slot_valid_r[1];

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// tb_rv_hazard_scoreboard
//   Directed bench for rv_hazard_scoreboard (REG_AW=5, DEPTH=3). Expected
//   outputs for each cycle are queued when the ID stimulus is driven and
//   popped and compared at the following falling clock edge.

module tb_rv_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       id_is_branch;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       ex_valid;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       exv;
    } exp_t;

    exp_t exp_q[$];

    rv_hazard_scoreboard #(.REG_AW(5), .DEPTH(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_branch (id_is_branch),
        .flush        (flush),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .ex_valid     (ex_valid)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic e_stall,
                            input logic [1:0] e_fa, input logic [1:0] e_fb,
                            input logic e_exv);
        exp_t e;
        e.tag   = tag;
        e.stall = e_stall;
        e.fa    = e_fa;
        e.fb    = e_fb;
        e.exv   = e_exv;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "/stall"},    {31'd0, stall},    {31'd0, e.stall});
        chk({e.tag, "/fwd_a"},    {30'd0, fwd_a},    {30'd0, e.fa});
        chk({e.tag, "/fwd_b"},    {30'd0, fwd_b},    {30'd0, e.fb});
        chk({e.tag, "/ex_valid"}, {31'd0, ex_valid}, {31'd0, e.exv});
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic rw, input logic ld, input logic br, input logic fl);
        id_valid     = v;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_regwrite  = rw;
        id_is_load   = ld;
        id_is_branch = br;
        flush        = fl;
    endtask

    // One pipeline cycle: drive ID, queue expectation, sample mid-cycle, advance.
    task automatic cyc(input string tag, input logic v, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic rw,
                       input logic ld, input logic br, input logic fl,
                       input logic e_stall, input logic [1:0] e_fa,
                       input logic [1:0] e_fb, input logic e_exv);
        drive(v, rd, rs1, rs2, u1, u2, rw, ld, br, fl);
        push_exp(tag, e_stall, e_fa, e_fb, e_exv);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        push_exp("reset", 1'b0, 2'd0, 2'd0, 1'b0);
        pop_check();
`ifdef HAZ_PERF_CNT_EN
        chk("reset/stall_cnt", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //   tag     v  rd  rs1 rs2 u1 u2 rw ld br fl   stall fa fb exv
        // Scenario 1: lw x5 ; add x6,x5,x1 -> one stall, then forward from WB
        cyc("s1_lw",    1, 5, 2, 0, 1, 0, 1, 1, 0, 0,   0, 0, 0, 0);
        cyc("s1_add",   1, 6, 5, 1, 1, 1, 1, 0, 0, 0,   1, 0, 0, 1);
        cyc("s1_hold",  1, 6, 5, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("s1_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 2, 0, 1);
        // Scenario 2: add x5 ; sub x7,x5,x5 -> both operands from MEM
        cyc("s2_add",   1, 5, 1, 2, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("s2_sub",   1, 7, 5, 5, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        cyc("s2_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1);
        // Scenario 3: add x5 ; add x5 ; or x8,x5,x0 -> youngest wins
        cyc("s3_add1",  1, 5, 1, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("s3_add2",  1, 5, 2, 2, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        cyc("s3_or",    1, 8, 5, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        cyc("s3_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1);
        // Scenario 4: addi x0 ; add x9,x0,x0 -> x0 never forwarded
        cyc("s4_addi",  1, 0, 0, 0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("s4_add",   1, 9, 0, 0, 1, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        cyc("s4_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        // Asynchronous reset with live state, then no stale forwarding
        cyc("r_add",    1, 5, 1, 2, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        drive(1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_exp("r_pre", 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        pop_check();
        #2 rst_n = 1'b0;
        #1;
        push_exp("r_async", 1'b0, 2'd0, 2'd0, 1'b0);
        pop_check();
`ifdef HAZ_PERF_CNT_EN
        chk("r_async/stall_cnt", stall_cnt, 32'd0);
`endif
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("r_add9",   1, 9, 5, 5, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("r_nostale",0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1);
        // Scenario 5: add x3 ; beq x3,x4 -> 1 stall ; lw x3 ; beq -> 2 stalls
        cyc("s5_add",   1, 3, 1, 2, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        cyc("s5_beq1",  1, 0, 3, 4, 1, 1, 0, 0, 1, 0,   1, 0, 0, 1);
        cyc("s5_beq1h", 1, 0, 3, 4, 1, 1, 0, 0, 1, 0,   0, 0, 0, 0);
        cyc("s5_lw",    1, 3, 1, 0, 1, 0, 1, 1, 0, 0,   0, 2, 0, 1);
        cyc("s5_beq2",  1, 0, 3, 4, 1, 1, 0, 0, 1, 0,   1, 0, 0, 1);
        cyc("s5_beq2h", 1, 0, 3, 4, 1, 1, 0, 0, 1, 0,   1, 0, 0, 0);
        cyc("s5_beq2r", 1, 0, 3, 4, 1, 1, 0, 0, 1, 0,   0, 0, 0, 0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_exp("s5_done", 1'b0, 2'd0, 2'd0, 1'b1);
        @(negedge clk);
        pop_check();
`ifdef HAZ_PERF_CNT_EN
        chk("s5/stall_cnt", stall_cnt, 32'd3);
`endif
        @(posedge clk);
        #1;
        // Scenario 6: load-use hazard coinciding with flush -> no stall, bubble
        cyc("s6_lw",    1, 5, 1, 0, 1, 0, 1, 1, 0, 0,   0, 0, 0, 0);
        cyc("s6_flush", 1, 6, 5, 1, 1, 1, 1, 0, 0, 1,   0, 0, 0, 1);
        cyc("s6_bubble",0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
`ifdef HAZ_PERF_CNT_EN
        chk("s6/stall_cnt", stall_cnt, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
